// File: rtl/n_tristate_pkg.sv
// Shared defaults and helpers for the N-bit tri-state bus driver.
package n_tristate_pkg;

    localparam int unsigned N_DEFAULT     = 4;
    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned N_MAX         = 64;

    // Released-bus fill: the low `width` bits are high-impedance, the rest are zero.
    function automatic logic [N_MAX-1:0] hiz(input int unsigned width);
        logic [N_MAX-1:0] r_fill;
        r_fill = '0;
        for (int i = 0; i < N_MAX; i++) begin
            if (i < width) r_fill[i] = 1'bz;
        end
        return r_fill;
    endfunction

endpackage

// File: rtl/n_tri_state_buffer_tristate_bit.sv
// One-bit enable-controlled bus driver; releases its output when not enabled.
module tristate_bit
    import n_tristate_pkg::*;
(
    input  logic     i_en,
    input  logic     i_d,
    output tri logic o_q
);

    assign o_q = i_en ? i_d : 1'bz;

endmodule

// File: rtl/n_tri_state_buffer.sv
// N-bit tri-state bus driver with registered drive/contention status.
// Optional drive-cycle counter compiled in with N_TRISTATE_DRIVE_COUNT_EN.
module n_tri_state_buffer
    import n_tristate_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             control_bit,
    input  logic [N-1:0]     in_data,
    output tri logic [N-1:0] out_data,
    input  logic [N-1:0]     bus_sense,
    input  logic             clr_status,
    output logic             driving,
    output logic [N-1:0]     last_driven,
    output logic             contention
`ifdef N_TRISTATE_DRIVE_COUNT_EN
    ,
    output logic [CNT_W-1:0] drive_cycles
`endif
);

    if (N < 1 || N > N_MAX || CNT_W < 1) begin : g_bad_param
        $error("n_tri_state_buffer: N must be 1..64 and CNT_W at least 1");
    end

    // Combinational data path: every bit shares the single enable.
    for (genvar g = 0; g < N; g++) begin : g_bit
        tristate_bit u_bit (
            .i_en (control_bit),
            .i_d  (in_data[g]),
            .o_q  (out_data[g])
        );
    end

    logic         r_driving;
    logic [N-1:0] r_last_driven;
    logic         r_contention;
    logic         w_mismatch;

    // Unknown or floating bits read back while driving count as contention.
    assign w_mismatch = !(bus_sense === in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_driving     <= 1'b0;
            r_last_driven <= '0;
            r_contention  <= 1'b0;
        end else begin
            r_driving <= control_bit;
            if (control_bit) r_last_driven <= in_data;
            // Set has priority over clear so a contention in the clearing cycle is not lost.
            if (control_bit && w_mismatch) r_contention <= 1'b1;
            else if (clr_status)           r_contention <= 1'b0;
        end
    end

    assign driving     = r_driving;
    assign last_driven = r_last_driven;
    assign contention  = r_contention;

`ifdef N_TRISTATE_DRIVE_COUNT_EN
    logic [CNT_W-1:0] r_drive_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drive_cycles <= '0;
        end else if (clr_status) begin
            r_drive_cycles <= '0;
        end else if (control_bit && (r_drive_cycles != '1)) begin
            r_drive_cycles <= r_drive_cycles + CNT_W'(1);
        end
    end

    assign drive_cycles = r_drive_cycles;
`endif

endmodule

// File: tb/tb_n_tri_state_buffer.sv
// Directed, table-driven bench for n_tri_state_buffer (N = 4).
module tb_n_tri_state_buffer;
    import n_tristate_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          rst_n;
    logic          control_bit;
    logic [W-1:0]  in_data;
    logic [W-1:0]  bus_sense;
    logic          clr_status;
    logic          driving;
    logic [W-1:0]  last_driven;
    logic          contention;
    logic          pull_en;
    logic [W-1:0]  pull_val;
    wire  [W-1:0]  bus;
`ifdef N_TRISTATE_DRIVE_COUNT_EN
    logic [CW-1:0] drive_cycles;
`endif

    // A second bench-side driver occupies the bus whenever the DUT should have released it.
    assign bus = pull_en ? pull_val : 4'bzzzz;

    n_tri_state_buffer #(.N(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .control_bit  (control_bit),
        .in_data      (in_data),
        .out_data     (bus),
        .bus_sense    (bus_sense),
        .clr_status   (clr_status),
        .driving      (driving),
        .last_driven  (last_driven),
        .contention   (contention)
`ifdef N_TRISTATE_DRIVE_COUNT_EN
        ,
        .drive_cycles (drive_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         ctrl;
        logic [W-1:0] din;
        logic [W-1:0] sense;
        logic         clr;
        logic         pen;
        logic [W-1:0] pval;
        logic [W-1:0] exp_bus;
        logic         exp_drv;
        logic [W-1:0] exp_last;
        logic         exp_cont;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // ctrl din      sense    clr pen pval     exp_bus  drv last     cont
        vecs[0] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1101, 4'b1101, 1'b0, 4'b0000, 1'b0};
        vecs[1] = '{1'b1, 4'b1001, 4'b1001, 1'b0, 1'b0, 4'b0000, 4'b1001, 1'b1, 4'b1001, 1'b0};
        vecs[2] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'b1101, 4'b1101, 1'b0, 4'b1001, 1'b0};
        vecs[3] = '{1'b1, 4'b1111, 4'b1011, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 4'b1111, 1'b1};
        vecs[4] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0110, 4'b0110, 1'b0, 4'b1111, 1'b1};
        vecs[5] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 4'b1111, 1'b0};
        vecs[6] = '{1'b1, 4'b1111, 4'b1011, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 4'b1111, 1'b1};
        vecs[7] = '{1'b1, 4'b1111, 4'b1011, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 4'b1111, 1'b1};
        vecs[8] = '{1'b0, 4'b0101, 4'b0000, 1'b1, 1'b1, 4'b1010, 4'b1010, 1'b0, 4'b1111, 1'b0};
        vecs[9] = '{1'b1, 4'b0110, 4'b0110, 1'b0, 1'b0, 4'b0000, 4'b0110, 1'b1, 4'b0110, 1'b0};

        rst_n       = 1'b0;
        control_bit = 1'b0;
        in_data     = '0;
        bus_sense   = '0;
        clr_status  = 1'b0;
        pull_en     = 1'b1;
        pull_val    = 4'b1101;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_driving",     64'(driving),     64'd0);
        chk("reset_last_driven", 64'(last_driven), 64'd0);
        chk("reset_contention",  64'(contention),  64'd0);
`ifdef N_TRISTATE_DRIVE_COUNT_EN
        chk("reset_drive_cycles", 64'(drive_cycles), 64'd0);
`endif
        chk("reset_bus_released", 64'(bus), 64'(4'b1101));
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            control_bit = vecs[i].ctrl;
            in_data     = vecs[i].din;
            bus_sense   = vecs[i].sense;
            clr_status  = vecs[i].clr;
            pull_en     = vecs[i].pen;
            pull_val    = vecs[i].pval;
            #1;
            chk($sformatf("v%0d_bus", i), 64'(bus), 64'(vecs[i].exp_bus));
            @(posedge clk);
            #2;
            chk($sformatf("v%0d_driving", i),     64'(driving),     64'(vecs[i].exp_drv));
            chk($sformatf("v%0d_last_driven", i), 64'(last_driven), 64'(vecs[i].exp_last));
            chk($sformatf("v%0d_contention", i),  64'(contention),  64'(vecs[i].exp_cont));
        end

        // Bus follows in_data with no clock edge in between.
        control_bit = 1'b1;
        pull_en     = 1'b0;
        clr_status  = 1'b0;
        in_data     = 4'b0011;
        bus_sense   = 4'b0011;
        #1;
        chk("comb_bus_a", 64'(bus), 64'(4'b0011));
        in_data   = 4'b1100;
        bus_sense = 4'b1100;
        #1;
        chk("comb_bus_b", 64'(bus), 64'(4'b1100));
        chk("comb_last_held", 64'(last_driven), 64'(4'b0110));

        // Fresh reset, then drive 5 cycles with contention, then reset mid-drive.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_contention", 64'(contention), 64'd0);
        rst_n       = 1'b1;
        control_bit = 1'b0;
        pull_en     = 1'b1;
        pull_val    = 4'b0000;
        @(posedge clk);
        #2;
        control_bit = 1'b1;
        pull_en     = 1'b0;
        in_data     = 4'b1111;
        bus_sense   = 4'b1011;
        repeat (5) @(posedge clk);
        #2;
        chk("drive5_contention", 64'(contention),  64'd1);
        chk("drive5_last",       64'(last_driven), 64'(4'b1111));
`ifdef N_TRISTATE_DRIVE_COUNT_EN
        chk("drive5_cycles", 64'(drive_cycles), 64'd5);
`endif
        rst_n = 1'b0;
        #1;
        chk("midrst_driving",    64'(driving),     64'd0);
        chk("midrst_last",       64'(last_driven), 64'd0);
        chk("midrst_contention", 64'(contention),  64'd0);
        chk("midrst_bus",        64'(bus),         64'(4'b1111));
`ifdef N_TRISTATE_DRIVE_COUNT_EN
        chk("midrst_cycles", 64'(drive_cycles), 64'd0);
`endif
        @(posedge clk);
        #2;
        chk("inrst_bus", 64'(bus), 64'(4'b1111));
        chk("inrst_driving", 64'(driving), 64'd0);
        in_data = 4'b0101;
        #1;
        chk("inrst_bus_follow", 64'(bus), 64'(4'b0101));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
